// File: rtl/i2c_reg_target.sv
// i2c_reg_target: I2C target with an 8-bit register file, auto-incrementing pointer and repeated START.
// Bus lines are oversampled on clk; SDA is only ever pulled low.
module i2c_reg_target #(
    parameter logic [6:0] I2CAddress = 7'h55,
    parameter int         Depth      = 16,
    localparam int        PW         = $clog2(Depth)
) (
    input  logic          clk,
    input  logic          reset,
    inout  wire           sda,
    inout  wire           scl,
    input  logic          host_wr_en,
    input  logic [PW-1:0] host_addr,
    input  logic [7:0]    host_wr_data,
    output logic [7:0]    host_rd_data,
    output logic          reg_wr_valid,
    output logic [PW-1:0] reg_wr_addr,
    output logic [7:0]    reg_wr_data,
    output logic          bus_active
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    scl_q, scl_d, sda_q, sda_d;
    logic          rise_q, rise_d, fall_q, fall_d, start_q, start_d, stop_q, stop_d, bit_q, bit_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    sh_q, sh_d, byte_in;
    logic [PW-1:0] ptr_q, ptr_d, wa_q, wa_d;
    logic          rw_q, rw_d, ph_q, ph_d, oe_q, oe_d, bus_q, bus_d, wv_q, wv_d;
    logic [7:0]    wd_q, wd_d;
    logic [7:0]    regs_q [Depth];
    logic [7:0]    regs_d [Depth];

    assign sda          = oe_q ? 1'b0 : 1'bz;
    assign host_rd_data = regs_q[host_addr];
    assign reg_wr_valid = wv_q;
    assign reg_wr_addr  = wa_q;
    assign reg_wr_data  = wd_q;
    assign bus_active   = bus_q;

    always_comb begin
        scl_d   = {scl_q[1:0], scl};
        sda_d   = {sda_q[1:0], sda};
        rise_d  = scl_q[1] & ~scl_q[2];
        fall_d  = ~scl_q[1] & scl_q[2];
        start_d = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
        stop_d  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
        bit_d   = sda_q[1];
        byte_in = {sh_q[6:0], bit_q};
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        ptr_d   = ptr_q;
        rw_d    = rw_q;
        ph_d    = ph_q;
        oe_d    = oe_q;
        bus_d   = bus_q;
        wv_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        regs_d  = regs_q;
        if (host_wr_en) regs_d[host_addr] = host_wr_data;
        if (start_q) begin
            state_d = ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            bus_d   = 1'b1;
        end else if (stop_q) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            bus_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WR_DATA: if (rise_q) begin
                    sh_d  = byte_in;
                    cnt_d = cnt_q + 4'd1;
                    ph_d  = 1'b0;
                    if (cnt_q == 4'd7) begin
                        cnt_d = 4'd0;
                        if (state_q == ADDR) begin
                            rw_d    = byte_in[0];
                            state_d = byte_in[7:1] == I2CAddress ? ADDR_ACK : IGNORE;
                        end else if (state_q == PTR) begin
                            ptr_d   = byte_in[PW-1:0];
                            state_d = PTR_ACK;
                        end else begin
                            regs_d[ptr_q] = byte_in;
                            wv_d    = 1'b1;
                            wa_d    = ptr_q;
                            wd_d    = byte_in;
                            ptr_d   = ptr_q + 1'b1;
                            state_d = WR_ACK;
                        end
                    end
                end
                // First falling edge starts the ACK low pulse, the second ends it.
                ADDR_ACK, PTR_ACK, WR_ACK: if (fall_q) begin
                    ph_d = ~ph_q;
                    oe_d = ~ph_q;
                    if (ph_q) begin
                        cnt_d = 4'd0;
                        if (state_q == ADDR_ACK && rw_q) begin
                            sh_d    = {regs_q[ptr_q][6:0], 1'b0};
                            oe_d    = ~regs_q[ptr_q][7];
                            state_d = RD_DATA;
                        end else begin
                            state_d = state_q == ADDR_ACK ? PTR : WR_DATA;
                        end
                    end
                end
                // Shifter holds the bits still to be sent, next one in bit 7.
                RD_DATA: if (rise_q) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (fall_q) begin
                    if (cnt_q == 4'd8) begin
                        oe_d    = 1'b0;
                        ptr_d   = ptr_q + 1'b1;
                        ph_d    = 1'b0;
                        state_d = RD_ACK;
                    end else begin
                        oe_d = ~sh_q[7];
                        sh_d = {sh_q[6:0], 1'b0};
                    end
                end
                RD_ACK: if (rise_q) begin
                    if (bit_q) state_d = IGNORE;
                    else ph_d = 1'b1;
                end else if (fall_q && ph_q) begin
                    sh_d    = {regs_q[ptr_q][6:0], 1'b0};
                    oe_d    = ~regs_q[ptr_q][7];
                    cnt_d   = 4'd0;
                    state_d = RD_DATA;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            scl_q   <= '1;
            sda_q   <= '1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            bit_q   <= 1'b1;
            cnt_q   <= '0;
            sh_q    <= '0;
            ptr_q   <= '0;
            rw_q    <= 1'b0;
            ph_q    <= 1'b0;
            oe_q    <= 1'b0;
            bus_q   <= 1'b0;
            wv_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            regs_q  <= '{default: 8'h00};
        end else begin
            state_q <= state_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            ptr_q   <= ptr_d;
            rw_q    <= rw_d;
            ph_q    <= ph_d;
            oe_q    <= oe_d;
            bus_q   <= bus_d;
            wv_q    <= wv_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            regs_q  <= regs_d;
        end
    end
endmodule

// File: tb/tb_i2c_reg_target.sv
// tb_i2c_reg_target: directed bench acting as an I2C master against i2c_reg_target.
module tb_i2c_reg_target;
    localparam int Q = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    tri1        sda, scl;
    logic       m_sda_low = 1'b0, m_scl_low = 1'b0;
    logic       host_wr_en = 1'b0;
    logic [3:0] host_addr = 4'd0;
    logic [7:0] host_wr_data = 8'h00;
    logic [7:0] host_rd_data;
    logic       reg_wr_valid;
    logic [3:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       bus_active;
    int         checks = 0, passed = 0, dut_low = 0;
    logic [11:0] wl[$];

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    assign scl = m_scl_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_reg_target #(.I2CAddress(7'h55), .Depth(16)) dut (
        .clk(clk), .reset(reset), .sda(sda), .scl(scl),
        .host_wr_en(host_wr_en), .host_addr(host_addr), .host_wr_data(host_wr_data),
        .host_rd_data(host_rd_data), .reg_wr_valid(reg_wr_valid), .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data), .bus_active(bus_active)
    );

    // Log register writes and count cycles where only the target can be pulling SDA low.
    always @(negedge clk) begin
        if (reg_wr_valid === 1'b1) wl.push_back({reg_wr_addr, reg_wr_data});
        if (sda === 1'b0 && !m_sda_low) dut_low++;
    end

    task automatic i2c_start();
        #Q m_sda_low = 1'b0;
        #Q m_scl_low = 1'b0;
        #Q m_sda_low = 1'b1;
        #Q m_scl_low = 1'b1;
    endtask

    task automatic i2c_stop();
        #Q m_sda_low = 1'b1;
        #Q m_scl_low = 1'b0;
        #Q m_sda_low = 1'b0;
        #Q;
    endtask

    task automatic clk_bit(input logic b, output logic r);
        #Q m_sda_low = ~b;
        #Q m_scl_low = 1'b0;
        #Q r = sda;
        #Q m_scl_low = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
        clk_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d, output logic line);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, r);
            d[i] = r;
        end
        clk_bit(mack, line);
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk);
        #2 host_addr = a; host_wr_data = d; host_wr_en = 1'b1;
        @(posedge clk);
        #2 host_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        checks++; if (sda !== 1'b1) $display("FAIL reset_sda got %b want 1", sda); else passed++;
        checks++; if (bus_active !== 1'b0) $display("FAIL reset_bus got %b want 0", bus_active); else passed++;
        checks++; if (reg_wr_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", reg_wr_valid); else passed++;
        checks++; if (reg_wr_addr !== 4'd0) $display("FAIL reset_waddr got %h want 0", reg_wr_addr); else passed++;
        checks++; if (reg_wr_data !== 8'h00) $display("FAIL reset_wdata got %h want 00", reg_wr_data); else passed++;
        checks++; if (host_rd_data !== 8'h00) $display("FAIL reset_reg0 got %h want 00", host_rd_data); else passed++;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_bus_latency();
        @(posedge clk);
        #2 m_sda_low = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_active !== 1'b0) $display("FAIL start_lat3 got %b want 0", bus_active); else passed++;
        @(posedge clk);
        #1;
        checks++; if (bus_active !== 1'b1) $display("FAIL start_lat4 got %b want 1", bus_active); else passed++;
        repeat (10) @(posedge clk);
        #2 m_sda_low = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_active !== 1'b1) $display("FAIL stop_lat3 got %b want 1", bus_active); else passed++;
        @(posedge clk);
        #1;
        checks++; if (bus_active !== 1'b0) $display("FAIL stop_lat4 got %b want 0", bus_active); else passed++;
    endtask

    task automatic test_write3();
        logic a;
        logic [7:0] d [3] = '{8'h11, 8'h22, 8'h33};
        int n0 = wl.size();
        i2c_start();
        send_byte(8'hAA, a);
        checks++; if (a !== 1'b0) $display("FAIL w3_addr_ack got %b want 0", a); else passed++;
        send_byte(8'h07, a);
        checks++; if (a !== 1'b0) $display("FAIL w3_ptr_ack got %b want 0", a); else passed++;
        for (int i = 0; i < 3; i++) begin
            send_byte(d[i], a);
            checks++; if (a !== 1'b0) $display("FAIL w3_data_ack%0d got %b want 0", i, a); else passed++;
        end
        checks++; if (bus_active !== 1'b1) $display("FAIL w3_bus_mid got %b want 1", bus_active); else passed++;
        i2c_stop();
        checks++; if (bus_active !== 1'b0) $display("FAIL w3_bus_end got %b want 0", bus_active); else passed++;
        checks++; if (wl.size() - n0 != 3) $display("FAIL w3_pulses got %0d want 3", wl.size() - n0); else passed++;
        for (int i = 0; i < 3 && n0 + i < wl.size(); i++) begin
            checks++;
            if (wl[n0 + i] !== {4'd7 + 4'(i), d[i]}) $display("FAIL w3_pulse%0d got %h want %h", i, wl[n0 + i], {4'd7 + 4'(i), d[i]});
            else passed++;
        end
        for (int i = 0; i < 3; i++) begin
            host_addr = 4'd7 + 4'(i);
            #1;
            checks++; if (host_rd_data !== d[i]) $display("FAIL w3_reg%0d got %h want %h", 7 + i, host_rd_data, d[i]); else passed++;
        end
    endtask

    task automatic test_read_rs();
        logic a, line;
        logic [7:0] v;
        host_write(4'd10, 8'h5C);
        i2c_start();
        send_byte(8'hAA, a);
        checks++; if (a !== 1'b0) $display("FAIL rd_addr_ack got %b want 0", a); else passed++;
        send_byte(8'h08, a);
        checks++; if (a !== 1'b0) $display("FAIL rd_ptr_ack got %b want 0", a); else passed++;
        i2c_start();
        send_byte(8'hAB, a);
        checks++; if (a !== 1'b0) $display("FAIL rd_raddr_ack got %b want 0", a); else passed++;
        recv_byte(1'b0, v, line);
        checks++; if (v !== 8'h22) $display("FAIL rd_byte0 got %h want 22", v); else passed++;
        recv_byte(1'b1, v, line);
        checks++; if (v !== 8'h33) $display("FAIL rd_byte1 got %h want 33", v); else passed++;
        checks++; if (line !== 1'b1) $display("FAIL rd_nack_released got %b want 1", line); else passed++;
        i2c_stop();
        i2c_start();
        send_byte(8'hAB, a);
        checks++; if (a !== 1'b0) $display("FAIL rd_ptr10_ack got %b want 0", a); else passed++;
        recv_byte(1'b1, v, line);
        checks++; if (v !== 8'h5C) $display("FAIL rd_ptr10 got %h want 5c", v); else passed++;
        i2c_stop();
    endtask

    task automatic test_mismatch();
        logic a;
        int n0 = wl.size();
        int l0 = dut_low;
        logic [7:0] exp_r [4] = '{8'h00, 8'h11, 8'h22, 8'h33};
        logic [3:0] idx [4] = '{4'd1, 4'd7, 4'd8, 4'd9};
        i2c_start();
        send_byte(8'h54, a);
        checks++; if (a !== 1'b1) $display("FAIL mm_addr_nack got %b want 1", a); else passed++;
        send_byte(8'h01, a);
        send_byte(8'hFF, a);
        i2c_stop();
        checks++; if (dut_low != l0) $display("FAIL mm_sda_driven got %0d cycles want 0", dut_low - l0); else passed++;
        checks++; if (wl.size() != n0) $display("FAIL mm_pulses got %0d want 0", wl.size() - n0); else passed++;
        for (int i = 0; i < 4; i++) begin
            host_addr = idx[i];
            #1;
            checks++; if (host_rd_data !== exp_r[i]) $display("FAIL mm_reg%0d got %h want %h", idx[i], host_rd_data, exp_r[i]); else passed++;
        end
    endtask

    task automatic test_wrap();
        logic a;
        int n0 = wl.size();
        i2c_start();
        send_byte(8'hAA, a);
        send_byte(8'h0F, a);
        send_byte(8'hA5, a);
        send_byte(8'h5A, a);
        checks++; if (a !== 1'b0) $display("FAIL wrap_ack got %b want 0", a); else passed++;
        i2c_stop();
        host_addr = 4'd15;
        #1;
        checks++; if (host_rd_data !== 8'hA5) $display("FAIL wrap_reg15 got %h want a5", host_rd_data); else passed++;
        host_addr = 4'd0;
        #1;
        checks++; if (host_rd_data !== 8'h5A) $display("FAIL wrap_reg0 got %h want 5a", host_rd_data); else passed++;
        checks++;
        if (wl.size() != n0 + 2 || wl[n0] !== 12'hFA5 || wl[n0 + 1] !== 12'h05A) $display("FAIL wrap_pulses got %0d entries want f,a5 then 0,5a", wl.size() - n0);
        else passed++;
        i2c_start();
        send_byte(8'hAA, a);
        send_byte(8'h1F, a);
        send_byte(8'h77, a);
        i2c_stop();
        host_addr = 4'd15;
        #1;
        checks++; if (host_rd_data !== 8'h77) $display("FAIL wrap_ptr1f got %h want 77", host_rd_data); else passed++;
    endtask

    task automatic test_host_preload();
        logic a, line, seen;
        logic [7:0] v;
        host_write(4'd3, 8'hC3);
        #1;
        checks++; if (host_rd_data !== 8'hC3) $display("FAIL hp_rd got %h want c3", host_rd_data); else passed++;
        i2c_start();
        send_byte(8'hAA, a);
        send_byte(8'h03, a);
        i2c_start();
        send_byte(8'hAB, a);
        recv_byte(1'b1, v, line);
        checks++; if (v !== 8'hC3) $display("FAIL hp_i2c_read got %h want c3", v); else passed++;
        i2c_stop();
        seen = 1'b0;
        i2c_start();
        send_byte(8'hAA, a);
        send_byte(8'h04, a);
        fork
            send_byte(8'h99, a);
            begin
                repeat (8) @(posedge scl);
                host_addr = 4'd4; host_wr_data = 8'h44; host_wr_en = 1'b1;
                for (int k = 0; k < 20 && !seen; k++) begin
                    @(posedge clk);
                    #1 seen = reg_wr_valid;
                end
                host_wr_en = 1'b0;
            end
        join
        i2c_stop();
        checks++; if (seen !== 1'b1) $display("FAIL hp_collide_pulse got %b want 1", seen); else passed++;
        host_addr = 4'd4;
        #1;
        checks++; if (host_rd_data !== 8'h99) $display("FAIL hp_collide_reg got %h want 99", host_rd_data); else passed++;
    endtask

    task automatic test_reset_mid_read();
        logic a, r;
        int n0;
        i2c_start();
        send_byte(8'hAA, a);
        send_byte(8'h05, a);
        i2c_start();
        send_byte(8'hAB, a);
        clk_bit(1'b1, r);
        checks++; if (r !== 1'b0) $display("FAIL rmr_bit7 got %b want 0", r); else passed++;
        #(Q / 2);
        checks++; if (sda !== 1'b0) $display("FAIL rmr_driven got %b want 0", sda); else passed++;
        reset = 1'b1;
        #1;
        checks++; if (sda !== 1'b1) $display("FAIL rmr_sda_released got %b want 1", sda); else passed++;
        checks++; if (bus_active !== 1'b0) $display("FAIL rmr_bus got %b want 0", bus_active); else passed++;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        i2c_stop();
        n0 = wl.size();
        i2c_start();
        send_byte(8'hAA, a);
        checks++; if (a !== 1'b0) $display("FAIL rmr_addr_ack got %b want 0", a); else passed++;
        send_byte(8'h02, a);
        send_byte(8'h6E, a);
        checks++; if (a !== 1'b0) $display("FAIL rmr_data_ack got %b want 0", a); else passed++;
        i2c_stop();
        checks++;
        if (wl.size() != n0 + 1 || wl[n0] !== 12'h26E) $display("FAIL rmr_pulse got %0d entries want one 2,6e", wl.size() - n0);
        else passed++;
        host_addr = 4'd2;
        #1;
        checks++; if (host_rd_data !== 8'h6E) $display("FAIL rmr_reg2 got %h want 6e", host_rd_data); else passed++;
        host_addr = 4'd7;
        #1;
        checks++; if (host_rd_data !== 8'h00) $display("FAIL rmr_reg7_cleared got %h want 00", host_rd_data); else passed++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bus_latency();
        test_write3();
        test_read_rs();
        test_mismatch();
        test_wrap();
        test_host_preload();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
